mdio_phy_responder: RTL and testbench

- Clause-22 MDIO target that answers the Ethernet MAC's MDIO master (mdc / mdio_out / mdio_oen) in the system.
- Stands in for a PHY management interface during bring-up and simulation.
- Decodes read and write frames, holds a small PHY register file, and drives read data back on the shared MDIO line.
- Runs entirely on the system clock. It oversamples MDC and MDIO and never clocks anything on MDC.

---
 rtl/mdio_phy_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO management target running on the system clock.
// MDC/MDIO are oversampled; a small PHY register file answers read and write frames.
module mdio_phy_responder #(
   parameter logic [4:0]  PHY_ADDR     = 5'd1,
   parameter int          PREAMBLE_MIN = 32,
   parameter logic [15:0] PHY_ID1      = 16'h0022,
   parameter logic [15:0] PHY_ID2      = 16'h1622,
   parameter logic [15:0] REG0_RST     = 16'h1140,
   parameter int          TIMEOUT      = 4096
) (
   input  logic        clk_32_clk,
   input  logic        reset_reset_n,
   input  logic        mdc,
   input  logic        mdio_in,
   output logic        mdio_out,
   output logic        mdio_oen,
   input  logic [15:0] status_in,
   output logic        wr_strobe,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data
);

   localparam int PW = $clog2(PREAMBLE_MIN + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA_RD, S_TA_WR, S_RDATA, S_WDATA, S_SKIP
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [WW-1:0]    wdog_q, wdog_d;
   logic             is_rd_q, is_rd_d;
   logic             mdc_meta_q, mdc_sync_q, mdc_prev_q;
   logic             mdio_meta_q, mdio_sync_q;
   logic             oen_q, oen_d, out_q, out_d;
   logic             strobe_q, strobe_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [15:0]      wr_data_q, wr_data_d;
   logic [15:0]      reg0_q, reg0_d;
   logic [3:0][15:0] regx_q, regx_d;
   logic [15:0]      shift_q, shift_d;
   logic [4:0]       phyad_q, phyad_d, regad_q, regad_d;

   logic             rise, bit_s, timeout;
   logic [4:0]       regad_nxt;
   logic [15:0]      rd_word, wword;

   function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
      return (v < PW'(PREAMBLE_MIN)) ? v + 1'b1 : v;
   endfunction

   assign rise      = mdc_sync_q & ~mdc_prev_q;
   assign bit_s     = mdio_sync_q;
   assign regad_nxt = {shift_q[3:0], bit_s};
   assign wword     = {shift_q[14:0], bit_s};
   assign timeout   = (state_q != S_IDLE) && !rise && (wdog_q == WW'(TIMEOUT - 1));

   // Read data is snapshotted from this mux at the REGAD-complete edge
   always_comb begin
      rd_word = 16'h0000;
      case (regad_nxt)
         5'd0:                rd_word = reg0_q & 16'h7FFF;
         5'd1:                rd_word = status_in;
         5'd2:                rd_word = PHY_ID1;
         5'd3:                rd_word = PHY_ID2;
         5'd4, 5'd5, 5'd6, 5'd7: rd_word = regx_q[regad_nxt[1:0]];
         default:             rd_word = 16'h0000;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pre_d     = pre_q;
      wdog_d    = '0;
      is_rd_d   = is_rd_q;
      oen_d     = oen_q;
      out_d     = out_q;
      strobe_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      reg0_d    = reg0_q;
      regx_d    = regx_q;
      shift_d   = shift_q;
      phyad_d   = phyad_q;
      regad_d   = regad_q;
      if (state_q != S_IDLE && !rise) wdog_d = wdog_q + 1'b1;
      if (timeout) begin
         state_d = S_IDLE;
         oen_d   = 1'b1;
         out_d   = 1'b0;
         pre_d   = '0;
         wdog_d  = '0;
      end else if (rise) begin
         case (state_q)
            S_IDLE: begin
               if (bit_s) pre_d = sat_inc(pre_q);
               else begin
                  pre_d = '0;
                  if (pre_q >= PW'(PREAMBLE_MIN)) state_d = S_ST2;
               end
            end
            S_ST2: begin
               cnt_d   = '0;
               state_d = bit_s ? S_OP : S_IDLE;
            end
            S_OP: begin
               shift_d = wword;
               if (cnt_q == 5'd0) cnt_d = 5'd1;
               else begin
                  cnt_d = '0;
                  case ({shift_q[0], bit_s})
                     2'b10:   begin is_rd_d = 1'b1; state_d = S_PHYAD; end
                     2'b01:   begin is_rd_d = 1'b0; state_d = S_PHYAD; end
                     default: state_d = S_IDLE;
                  endcase
               end
            end
            S_PHYAD: begin
               shift_d = wword;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == 5'd4) begin
                  phyad_d = regad_nxt;
                  cnt_d   = '0;
                  state_d = S_REGAD;
               end
            end
            S_REGAD: begin
               shift_d = wword;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == 5'd4) begin
                  regad_d = regad_nxt;
                  shift_d = rd_word;
                  cnt_d   = '0;
                  if (phyad_q != PHY_ADDR) state_d = S_SKIP;
                  else                     state_d = is_rd_q ? S_TA_RD : S_TA_WR;
               end
            end
            // PHY drives the second turnaround bit low
            S_TA_RD: begin
               oen_d   = 1'b0;
               out_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_RDATA;
            end
            S_RDATA: begin
               if (cnt_q == 5'd16) begin
                  oen_d   = 1'b1;
                  out_d   = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  out_d   = shift_q[15];
                  shift_d = {shift_q[14:0], 1'b0};
                  cnt_d   = cnt_q + 1'b1;
               end
            end
            S_TA_WR: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == 5'd1) begin
                  cnt_d   = '0;
                  state_d = S_WDATA;
               end
            end
            S_WDATA: begin
               shift_d = wword;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == 5'd15) begin
                  strobe_d  = 1'b1;
                  wr_addr_d = regad_q;
                  wr_data_d = wword;
                  state_d   = S_IDLE;
                  if (regad_q == 5'd0) begin
                     if (wword[15]) begin
                        reg0_d = REG0_RST;
                        regx_d = '0;
                     end else begin
                        reg0_d = {1'b0, wword[14:0]};
                     end
                  end else if (regad_q[4:2] == 3'b001) begin
                     regx_d[regad_q[1:0]] = wword;
                  end
               end
            end
            S_SKIP: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == 5'd17) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_32_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pre_q       <= '0;
         wdog_q      <= '0;
         is_rd_q     <= 1'b0;
         mdc_meta_q  <= 1'b0;
         mdc_sync_q  <= 1'b0;
         mdc_prev_q  <= 1'b0;
         mdio_meta_q <= 1'b1;
         mdio_sync_q <= 1'b1;
         oen_q       <= 1'b1;
         out_q       <= 1'b0;
         strobe_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         reg0_q      <= REG0_RST;
         regx_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pre_q       <= pre_d;
         wdog_q      <= wdog_d;
         is_rd_q     <= is_rd_d;
         mdc_meta_q  <= mdc;
         mdc_sync_q  <= mdc_meta_q;
         mdc_prev_q  <= mdc_sync_q;
         mdio_meta_q <= mdio_in;
         mdio_sync_q <= mdio_meta_q;
         oen_q       <= oen_d;
         out_q       <= out_d;
         strobe_q    <= strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         reg0_q      <= reg0_d;
         regx_q      <= regx_d;
      end
   end

   // Frame shift/address registers carry no reset; they are always loaded before use
   always_ff @(posedge clk_32_clk) begin
      shift_q <= shift_d;
      phyad_q <= phyad_d;
      regad_q <= regad_d;
   end

   assign mdio_out  = out_q;
   assign mdio_oen  = oen_q;
   assign wr_strobe = strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: bit-level MDIO master plus a register-map model.
module tb_mdio_phy_responder;

   localparam int HALF    = 4;
   localparam int TIMEOUT = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mdc = 1'b0;
   logic        master_drv = 1'b1;
   logic        mdio_in;
   logic        mdio_out, mdio_oen;
   logic [15:0] status_in = 16'h0000;
   logic        wr_strobe;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;

   int checks = 0;
   int errors = 0;
   int strobe_cnt = 0;

   logic [15:0] m_reg0;
   logic [15:0] m_r47 [4];

   always #5 clk = ~clk;

   // Open-drain style bus: the PHY wins while it drives, otherwise the master (1 = released/pulled up)
   assign mdio_in = (mdio_oen == 1'b0) ? mdio_out : master_drv;

   mdio_phy_responder dut (
      .clk_32_clk   (clk),
      .reset_reset_n(rst_n),
      .mdc          (mdc),
      .mdio_in      (mdio_in),
      .mdio_out     (mdio_out),
      .mdio_oen     (mdio_oen),
      .status_in    (status_in),
      .wr_strobe    (wr_strobe),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data)
   );

   always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_reg0 = 16'h1140;
      for (int i = 0; i < 4; i++) m_r47[i] = 16'h0000;
   endtask

   function automatic logic [15:0] model_read(input int a);
      if (a == 0) return m_reg0;
      if (a == 1) return status_in;
      if (a == 2) return 16'h0022;
      if (a == 3) return 16'h1622;
      if (a >= 4 && a <= 7) return m_r47[a-4];
      return 16'h0000;
   endfunction

   task automatic model_write(input int a, input logic [15:0] d);
      if (a == 0) begin
         if (d[15]) model_reset();
         else m_reg0 = {1'b0, d[14:0]};
      end else if (a >= 4 && a <= 7) begin
         m_r47[a-4] = d;
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One MDC period: master changes its bit while MDC is low, samples just before MDC rises
   task automatic bit_cycle(input logic b, output logic bus_s, output logic oen_s);
      mdc = 1'b0;
      master_drv = b;
      wait_clk(HALF);
      bus_s = mdio_in;
      oen_s = mdio_oen;
      mdc = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic send_header(input int pre, input logic is_rd, input logic [4:0] phy,
                              input logic [4:0] ra);
      logic bs, os;
      logic [13:0] hdr;
      hdr = {2'b01, (is_rd ? 2'b10 : 2'b01), phy, ra};
      for (int i = 0; i < pre; i++) bit_cycle(1'b1, bs, os);
      for (int i = 13; i >= 0; i--) bit_cycle(hdr[i], bs, os);
   endtask

   task automatic do_frame(input int pre, input logic is_rd, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] wd,
                           output logic [15:0] rd, output int low_cnt,
                           output logic ta_ok, output logic post_oen);
      logic bs, os, b;
      send_header(pre, is_rd, phy, ra);
      rd = 16'h0000;
      low_cnt = 0;
      ta_ok = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (is_rd) b = 1'b1;
         else if (i < 2) b = (i == 0);
         else b = wd[17-i];
         bit_cycle(b, bs, os);
         if (os === 1'b0) low_cnt++;
         if (i == 1) ta_ok = (bs === 1'b0) && (os === 1'b0);
         if (i >= 2) rd = {rd[14:0], bs};
      end
      bit_cycle(1'b1, bs, os);
      post_oen = os;
   endtask

   task automatic read_chk(input string tag, input logic [4:0] ra, input logic [15:0] exp);
      logic [15:0] rd;
      int lc;
      logic ta, po;
      do_frame(32, 1'b1, 5'd1, ra, 16'h0, rd, lc, ta, po);
      chk({tag, "_data"}, rd, exp);
      chk({tag, "_oenlow"}, lc, 17);
      chk({tag, "_ta"}, ta, 1'b1);
      chk({tag, "_release"}, po, 1'b1);
   endtask

   task automatic write_chk(input string tag, input logic [4:0] ra, input logic [15:0] wd);
      logic [15:0] rd;
      int lc, s0;
      logic ta, po;
      s0 = strobe_cnt;
      do_frame(32, 1'b0, 5'd1, ra, wd, rd, lc, ta, po);
      chk({tag, "_strobe"}, strobe_cnt - s0, 1);
      chk({tag, "_addr"}, wr_addr, ra);
      chk({tag, "_wdata"}, wr_data, wd);
      model_write(ra, wd);
   endtask

   initial begin
      logic [15:0] rd;
      int lc, s0, n;
      logic ta, po, bs, os;
      logic is_rd;
      logic [4:0] phy, ra;
      logic [15:0] wd;

      model_reset();
      wait_clk(5);
      chk("rst_oen", mdio_oen, 1'b1);
      chk("rst_out", mdio_out, 1'b0);
      chk("rst_strobe", wr_strobe, 1'b0);
      chk("rst_waddr", wr_addr, 5'd0);
      chk("rst_wdata", wr_data, 16'h0);
      rst_n = 1'b1;
      wait_clk(5);

      read_chk("rd_id1", 5'd2, 16'h0022);
      read_chk("rd_id2", 5'd3, 16'h1622);

      write_chk("wr_r4", 5'd4, 16'hA5C3);
      read_chk("rd_r4", 5'd4, model_read(4));

      // Foreign PHY address: bus never driven, no write strobe
      s0 = strobe_cnt;
      do_frame(32, 1'b1, 5'd5, 5'd2, 16'h0, rd, lc, ta, po);
      chk("phy5_rd_oen", lc, 0);
      do_frame(32, 1'b0, 5'd5, 5'd4, 16'hFFFF, rd, lc, ta, po);
      chk("phy5_wr_oen", lc, 0);
      chk("phy5_strobe", strobe_cnt - s0, 0);
      read_chk("rd_r4_after_phy5", 5'd4, model_read(4));

      // Two zeros break up any leftover run of ones before the short preamble
      bit_cycle(1'b0, bs, os);
      bit_cycle(1'b0, bs, os);
      do_frame(31, 1'b1, 5'd1, 5'd2, 16'h0, rd, lc, ta, po);
      chk("pre31_oen", lc, 0);
      read_chk("rd_after_pre31", 5'd2, 16'h0022);

      write_chk("wr_r4b", 5'd4, 16'h1234);
      write_chk("wr_r0rst", 5'd0, 16'h8000);
      read_chk("rd_r0_after_rst", 5'd0, 16'h1140);
      read_chk("rd_r4_after_rst", 5'd4, 16'h0000);
      write_chk("wr_r0", 5'd0, 16'h0120);
      read_chk("rd_r0", 5'd0, model_read(0));

      status_in = 16'h782D;
      read_chk("rd_status", 5'd1, 16'h782D);

      // Stall mid-read with MDC held high
      send_header(32, 1'b1, 5'd1, 5'd2);
      for (int i = 0; i < 6; i++) bit_cycle(1'b1, bs, os);
      chk("stall_driving", mdio_oen, 1'b0);
      wait_clk(TIMEOUT - 40);
      chk("stall_hold", mdio_oen, 1'b0);
      n = 0;
      while (mdio_oen !== 1'b1 && n < 100) begin
         wait_clk(1);
         n++;
      end
      chk("stall_release", mdio_oen, 1'b1);
      read_chk("rd_after_stall", 5'd2, 16'h0022);

      for (int t = 0; t < 24; t++) begin
         is_rd = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
         phy = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
         wd = 16'($urandom);
         if (ra == 5'd0 && $urandom_range(0, 3) != 0) wd[15] = 1'b0;
         status_in = 16'($urandom);
         s0 = strobe_cnt;
         do_frame(32, is_rd, phy, ra, wd, rd, lc, ta, po);
         if (phy != 5'd1) begin
            chk("rnd_foreign_oen", lc, 0);
            chk("rnd_foreign_strobe", strobe_cnt - s0, 0);
         end else if (is_rd) begin
            chk("rnd_rd_data", rd, model_read(int'(ra)));
            chk("rnd_rd_oenlow", lc, 17);
         end else begin
            chk("rnd_wr_strobe", strobe_cnt - s0, 1);
            chk("rnd_wr_addr", wr_addr, ra);
            chk("rnd_wr_data", wr_data, wd);
            model_write(int'(ra), wd);
         end
      end

      // Reset mid-read releases the bus without waiting for a clock
      write_chk("wr_r5", 5'd5, 16'hBEEF);
      send_header(32, 1'b1, 5'd1, 5'd5);
      for (int i = 0; i < 8; i++) bit_cycle(1'b1, bs, os);
      chk("midrst_driving", mdio_oen, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_oen", mdio_oen, 1'b1);
      chk("midrst_waddr", wr_addr, 5'd0);
      chk("midrst_wdata", wr_data, 16'h0);
      model_reset();
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(3);
      read_chk("rd_r5_after_rst", 5'd5, 16'h0000);
      read_chk("rd_r0_after_hwrst", 5'd0, 16'h1140);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
